mindy_reset_sequencer: RTL and testbench
========================================

MINDY_RESET_SEQUENCER -- requirements
Module: mindy_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of downstream reset channels (legal range 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 20, meaning the number of cycles all channels are held in reset (legal range 1..255).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4, meaning the gap between one channel reporting ready and the next channel's release (legal range 0..255).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum wait for a channel's ready (legal range 1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port new_job, input, 1 bit: a high level in any cycle restarts the sequence.
REQ-008 SHALL have port ch_ready, input, NUM_CH bits: channel k reports out-of-reset complete.
REQ-009 SHALL have port ch_resetn, output, NUM_CH bits: active-low per-channel reset.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse when the sequence completes.
REQ-012 SHALL have port timeout_err, output, 1 bit: sticky flag, set when any channel times out.
REQ-013 SHALL have port err_ch, output, 3 bits: index of the first channel that timed out.

Function
REQ-014 SHALL implement states IDLE, HOLD, WAIT_RDY and GAP, with channel index k of width 3.
REQ-015 SHALL register all outputs, with no combinational path from any input to any output.
REQ-016 SHALL, in the first cycle after resetn deasserts, enter HOLD with the counter at HOLD_CYCLES, as if new_job had been seen.
REQ-017 SHALL, when new_job is high in cycle t in any state, enter HOLD at t+1 with ch_resetn all 0, k=0, counter=HOLD_CYCLES, and timeout_err and err_ch cleared; new_job overrides all other transitions.
REQ-018 SHALL, in HOLD, decrement the counter each cycle and, after exactly HOLD_CYCLES cycles, set ch_resetn[0]=1 and enter WAIT_RDY with counter=TIMEOUT_CYCLES.
REQ-019 SHALL, in WAIT_RDY for channel k, when ch_ready[k]=1, go to GAP with counter=STAGGER_CYCLES if k<NUM_CH-1, otherwise go to IDLE and pulse done.
REQ-020 SHALL, in WAIT_RDY, treat the counter reaching 0 with ch_ready[k]=0 as a timeout: set timeout_err, load err_ch=k only if timeout_err was previously 0, and proceed exactly as if ready had been seen.
REQ-021 SHALL, in GAP, decrement the counter and, when it is 0, set ch_resetn[k+1]=1, increment k and enter WAIT_RDY with counter=TIMEOUT_CYCLES; with STAGGER_CYCLES=0, GAP SHALL last exactly 1 cycle.
REQ-022 SHALL keep released channels high until the next new_job or reset; unreleased channels SHALL stay 0.
REQ-023 SHALL ignore ch_ready[j] for j≠k, and SHALL ignore ch_ready[k] while the state is not WAIT_RDY.
REQ-024 SHALL size the counter to clog2 of the largest of HOLD_CYCLES, STAGGER_CYCLES and TIMEOUT_CYCLES, plus 1 bit; the counter SHALL never wrap below 0.
REQ-025 SHALL, with NUM_CH=1, go from WAIT_RDY directly to IDLE and never enter GAP.

Reset
REQ-026 SHALL, while resetn=0, force ch_resetn=0, busy=0, done=0, timeout_err=0, err_ch=0, state=IDLE, k=0 and counter=0 asynchronously.
REQ-027 SHALL, when resetn asserts mid-sequence, abort immediately; the sequence SHALL restart per REQ-016 after resetn is released.

Structure
REQ-028 SHALL place the state enum typedef and the counter-width function in the shared package mindy_reset_pkg.
REQ-029 SHALL use one sub-module, mindy_rst_counter: a loadable down-counter with a zero flag, instantiated once.

Verification
REQ-030 SHALL cover the default parameters with all ch_ready tied to 1: resetn rises at cycle 0 → ch_resetn[0] rises at cycle 21, ch[1] at 27, ch[2] at 33, ch[3] at 39; done pulses once; busy falls with done.
REQ-031 SHALL cover new_job at cycle 30 mid-sequence: next cycle ch_resetn=0000, the full 20-cycle hold repeats, and err flags are cleared.
REQ-032 SHALL cover ch_ready[1] stuck at 0 with TIMEOUT_CYCLES=10: timeout_err=1, err_ch=1, ch[2] released 10+STAGGER+1 cycles after ch[1], and done still pulses.
REQ-033 SHALL cover NUM_CH=1 with STAGGER_CYCLES=0: exactly one release, no GAP state visited, and done occurs 1 cycle after ready.
REQ-034 SHALL cover resetn asserted asynchronously between clock edges during GAP: all outputs reach 0 before the next edge.
REQ-035 SHALL cover new_job held high for 5 cycles: HOLD restarts each cycle, and ch[0] is released HOLD_CYCLES cycles after the last high cycle.

Source files
------------

// File: rtl/mindy_reset_pkg.sv
// Shared definitions for the reset sequencer.
//   rst_state_e : sequencer states (IDLE, HOLD, WAIT_RDY, GAP)
//   CH_IDX_W    : width of the channel index k
//   cnt_width() : width of the shared down-counter, one bit wider than the
//                 clog2 of the largest cycle count it must be loaded with
package mindy_reset_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_RDY = 2'd2,
        GAP      = 2'd3
    } rst_state_e;

    localparam int CH_IDX_W = 3;

    function automatic int cnt_width(input int hold_c, input int stagger_c, input int timeout_c);
        int m;
        m = hold_c;
        if (stagger_c > m) m = stagger_c;
        if (timeout_c > m) m = timeout_c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/mindy_rst_counter.sv
// Loadable down-counter with a zero flag.
//   clk, resetn : clock and asynchronous active-low reset (clears count)
//   load        : load load_val this cycle (takes priority over dec)
//   load_val    : value to load
//   dec         : decrement by one; saturates at zero, never wraps
//   count       : current value
//   zero        : count == 0
module mindy_rst_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mindy_reset_sequencer.sv
// Staggered reset release for NUM_CH downstream channels.
// After reset (or any new_job) all channels are held in reset for
// HOLD_CYCLES, then released one at a time: channel k is released, the
// sequencer waits for ch_ready[k] (at most TIMEOUT_CYCLES), then waits a
// further gap before releasing channel k+1.
//   clk, resetn  : clock, asynchronous active-low reset
//   new_job      : level; restarts the sequence from HOLD in any state
//   ch_ready     : per-channel out-of-reset-complete indication
//   ch_resetn    : per-channel active-low reset (registered)
//   busy         : state is not IDLE (registered)
//   done         : one-cycle pulse when the last channel is ready/timed out
//   timeout_err  : sticky, set when any channel times out
//   err_ch       : index of the first channel that timed out
//   dbg_state    : current sequencer state
//
// Handshake: ch_ready is a level-sampled acknowledge with no back-pressure.
// It is only looked at for the channel currently released (index k) and only
// while in WAIT_RDY; a high sample there completes that channel. Ready bits
// of other channels, or in other states, have no effect.
module mindy_reset_sequencer
    import mindy_reset_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = 20,
    parameter int STAGGER_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                new_job,
    input  logic [NUM_CH-1:0]   ch_ready,
    output logic [NUM_CH-1:0]   ch_resetn,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [CH_IDX_W-1:0] err_ch,
    output rst_state_e          dbg_state
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    HOLD_LOAD    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]    STAGGER_LOAD = CNT_W'(STAGGER_CYCLES);
    localparam logic [CNT_W-1:0]    TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CH_IDX_W-1:0] LAST_CH      = CH_IDX_W'(NUM_CH - 1);

    rst_state_e          state_q, state_d;
    logic [CH_IDX_W-1:0] k_q, k_d, k_inc;
    logic                boot_q;
    logic [NUM_CH-1:0]   chr_d;
    logic                busy_d, done_d, terr_d;
    logic [CH_IDX_W-1:0] err_ch_d;
    logic                rdy_k;

    logic                cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]    cnt_load_val, cnt;
    logic                last_tick;

    mindy_rst_counter #(.WIDTH(CNT_W)) u_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // HOLD and WAIT_RDY act on the cycle the count would reach zero, so a
    // load of N gives exactly N cycles in the state. GAP acts once the count
    // is already zero, so it spans STAGGER_CYCLES+1 cycles (1 when 0).
    assign last_tick = (cnt <= CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        chr_d        = ch_resetn;
        done_d       = 1'b0;
        terr_d       = timeout_err;
        err_ch_d     = err_ch;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        k_inc        = k_q + CH_IDX_W'(1);

        rdy_k = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (k_q == CH_IDX_W'(i)) rdy_k = ch_ready[i];
        end

        // boot_q makes the first cycle out of reset behave like new_job.
        if (new_job || boot_q) begin
            state_d      = HOLD;
            k_d          = '0;
            chr_d        = '0;
            terr_d       = 1'b0;
            err_ch_d     = '0;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                HOLD: begin
                    if (last_tick) begin
                        chr_d[0]     = 1'b1;
                        state_d      = WAIT_RDY;
                        cnt_load     = 1'b1;
                        cnt_load_val = TIMEOUT_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                WAIT_RDY: begin
                    // A timeout completes the channel just like ready does.
                    if (rdy_k || last_tick) begin
                        if (!rdy_k) begin
                            terr_d = 1'b1;
                            if (!timeout_err) err_ch_d = k_q;
                        end
                        if (k_q == LAST_CH) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d      = GAP;
                            cnt_load     = 1'b1;
                            cnt_load_val = STAGGER_LOAD;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (k_inc == CH_IDX_W'(i)) chr_d[i] = 1'b1;
                        end
                        k_d          = k_inc;
                        state_d      = WAIT_RDY;
                        cnt_load     = 1'b1;
                        cnt_load_val = TIMEOUT_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            boot_q      <= 1'b1;
            ch_resetn   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            err_ch      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            boot_q      <= 1'b0;
            ch_resetn   <= chr_d;
            busy        <= busy_d;
            done        <= done_d;
            timeout_err <= terr_d;
            err_ch      <= err_ch_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mindy_reset_sequencer.sv
// Bench for mindy_reset_sequencer.
//   dut_a: NUM_CH=4, HOLD=20, STAGGER=4, TIMEOUT=10
//   dut_b: NUM_CH=1, HOLD=5,  STAGGER=0, TIMEOUT=6
// A timeline model predicts every output each cycle; directed runs pin the
// release edges (expected queue) and done timing with literal values.
module tb_mindy_reset_sequencer;
    import mindy_reset_pkg::*;

    localparam int A_N = 4, A_H = 20, A_S = 4, A_T = 10;
    localparam int B_N = 1, B_H = 5,  B_S = 0, B_T = 6;

    // ---------------- clock / reset / DUTs ----------------
    logic       clk, resetn;
    logic       nj_a, nj_b;
    logic [3:0] rdy_a;
    logic [0:0] rdy_b;
    logic [3:0] ch_resetn_a;
    logic [0:0] ch_resetn_b;
    logic       busy_a, done_a, terr_a, busy_b, done_b, terr_b;
    logic [2:0] err_ch_a, err_ch_b;
    rst_state_e dbg_state_a, dbg_state_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mindy_reset_sequencer #(.NUM_CH(A_N), .HOLD_CYCLES(A_H), .STAGGER_CYCLES(A_S), .TIMEOUT_CYCLES(A_T)) dut_a (
        .clk(clk), .resetn(resetn), .new_job(nj_a), .ch_ready(rdy_a), .ch_resetn(ch_resetn_a),
        .busy(busy_a), .done(done_a), .timeout_err(terr_a), .err_ch(err_ch_a), .dbg_state(dbg_state_a));

    mindy_reset_sequencer #(.NUM_CH(B_N), .HOLD_CYCLES(B_H), .STAGGER_CYCLES(B_S), .TIMEOUT_CYCLES(B_T)) dut_b (
        .clk(clk), .resetn(resetn), .new_job(nj_b), .ch_ready(rdy_b), .ch_resetn(ch_resetn_b),
        .busy(busy_b), .done(done_b), .timeout_err(terr_b), .err_ch(err_ch_b), .dbg_state(dbg_state_b));

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int e = 0;                  // index of the most recent rising edge
    logic [15:0] exp_q[$];      // expected dut_a releases: {channel, edge}
    int done_a_n = 0, done_a_e = 0, done_b_n = 0, done_b_e = 0;
    int rise_b_e = 0, gap_a_n = 0, gap_b_n = 0;
    logic [3:0] prev_a = '0;
    logic [0:0] prev_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    // ---------------- timeline model ----------------
    // Tracks the edge at which the current channel is due for release and
    // the edge it was released; outputs follow from those times.
    typedef struct {
        bit         active;
        bit         waiting;
        bit         boot;
        int         k;
        int         rel_at;
        int         w_start;
        logic [7:0] chr;
        bit         done;
        bit         terr;
        int         errch;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t r;
        r.active = 0; r.waiting = 0; r.boot = 1; r.k = 0; r.rel_at = 0; r.w_start = 0;
        r.chr = '0; r.done = 0; r.terr = 0; r.errch = 0;
        return r;
    endfunction

    function automatic model_t step(model_t m, int edge_n, logic nj, logic [7:0] rdy,
                                    int n, int h, int s, int t);
        model_t r;
        r = m;
        r.done = 0;
        if (nj || m.boot) begin
            r.boot = 0; r.active = 1; r.waiting = 0; r.k = 0;
            r.chr = '0; r.terr = 0; r.errch = 0;
            r.rel_at = edge_n + h;
        end else if (m.active) begin
            if (!m.waiting) begin
                if (edge_n == m.rel_at) begin
                    r.chr[m.k] = 1'b1;
                    r.waiting  = 1;
                    r.w_start  = edge_n;
                end
            end else if (rdy[m.k] || (edge_n - m.w_start) >= t) begin
                if (!rdy[m.k]) begin
                    if (!m.terr) r.errch = m.k;
                    r.terr = 1;
                end
                r.waiting = 0;
                if (m.k == n - 1) begin
                    r.active = 0;
                    r.done   = 1;
                end else begin
                    r.k      = m.k + 1;
                    r.rel_at = edge_n + s + 1;
                end
            end
        end
        return r;
    endfunction

    function automatic rst_state_e exp_state(model_t m);
        if (!m.active) return IDLE;
        if (m.waiting) return WAIT_RDY;
        if (m.k == 0)  return HOLD;
        return GAP;
    endfunction

    initial begin
        ma = model_reset();
        mb = model_reset();
    end

    // ---------------- model step + per-cycle compare ----------------
    always @(posedge clk) begin
        e = e + 1;
        if (!resetn) begin
            ma = model_reset();
            mb = model_reset();
        end else begin
            ma = step(ma, e, nj_a, 8'(rdy_a), A_N, A_H, A_S, A_T);
            mb = step(mb, e, nj_b, 8'(rdy_b), B_N, B_H, B_S, B_T);
        end
        #2;
        check("ch_resetn_a", 32'(ch_resetn_a), 32'(ma.chr[3:0]));
        check("busy_a",      32'(busy_a),      32'(ma.active));
        check("done_a",      32'(done_a),      32'(ma.done));
        check("terr_a",      32'(terr_a),      32'(ma.terr));
        check("err_ch_a",    32'(err_ch_a),    32'(ma.errch));
        check("state_a",     32'(dbg_state_a), 32'(exp_state(ma)));
        check("ch_resetn_b", 32'(ch_resetn_b), 32'(mb.chr[0]));
        check("busy_b",      32'(busy_b),      32'(mb.active));
        check("done_b",      32'(done_b),      32'(mb.done));
        check("terr_b",      32'(terr_b),      32'(mb.terr));
        check("err_ch_b",    32'(err_ch_b),    32'(mb.errch));
        check("state_b",     32'(dbg_state_b), 32'(exp_state(mb)));

        for (int i = 0; i < 4; i++) begin
            if (ch_resetn_a[i] && !prev_a[i]) begin
                logic [15:0] got, want;
                got  = {4'(i), 12'(e)};
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hffff;
                check("release_a", 32'(got), 32'(want));
            end
        end
        prev_a = ch_resetn_a;
        if (ch_resetn_b[0] && !prev_b[0]) rise_b_e = e;
        prev_b = ch_resetn_b;
        if (done_a) begin done_a_n++; done_a_e = e; end
        if (done_b) begin done_b_n++; done_b_e = e; end
        if (dbg_state_a == GAP) gap_a_n++;
        if (dbg_state_b == GAP) gap_b_n++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_to(input int target);
        while (e < target) @(negedge clk);
    endtask

    task automatic push_rel(input int ch, input int edge_n);
        exp_q.push_back({4'(ch), 12'(edge_n)});
    endtask

    task automatic pulse_nj_a();
        nj_a = 1'b1;
        @(negedge clk);
        nj_a = 1'b0;
    endtask

    // ---------------- directed runs ----------------
    initial begin
        int t0, s, s2, l;
        resetn = 1'b0; nj_a = 1'b0; nj_b = 1'b0; rdy_a = 4'b1111; rdy_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ch_resetn_a", 32'(ch_resetn_a), 0);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_state_a", 32'(dbg_state_a), 32'(IDLE));

        // Run 1: all ready, releases at 21/27/33/39, done at 40.
        resetn = 1'b1; t0 = e;
        done_a_n = 0;
        push_rel(0, t0 + 21); push_rel(1, t0 + 27); push_rel(2, t0 + 33); push_rel(3, t0 + 39);
        wait_to(t0 + 45);
        check("run1_done_edge", done_a_e - t0, 40);
        check("run1_done_count", done_a_n, 1);
        check("run1_release_q", exp_q.size(), 0);
        check("run1_busy", 32'(busy_a), 0);

        // Run 2: channel 1 never ready -> timeout after 10, ch2 15 later.
        rdy_a = 4'b1101; done_a_n = 0; s = e + 1;
        push_rel(0, s + 20); push_rel(1, s + 26); push_rel(2, s + 41); push_rel(3, s + 47);
        pulse_nj_a();
        wait_to(s + 55);
        check("run2_done_edge", done_a_e - s, 48);
        check("run2_done_count", done_a_n, 1);
        check("run2_terr", 32'(terr_a), 1);
        check("run2_err_ch", 32'(err_ch_a), 1);
        check("run2_release_q", exp_q.size(), 0);

        // Run 3: restart clears flags; timeout again; new_job mid-GAP; async reset in GAP.
        done_a_n = 0; s = e + 1;
        push_rel(0, s + 20); push_rel(1, s + 26); push_rel(0, s + 60);
        pulse_nj_a();
        check("run3_terr_cleared", 32'(terr_a), 0);
        check("run3_err_ch_cleared", 32'(err_ch_a), 0);
        check("run3_all_held", 32'(ch_resetn_a), 0);
        wait_to(s + 36);
        check("run3_terr_set", 32'(terr_a), 1);
        check("run3_err_ch_set", 32'(err_ch_a), 1);
        wait_to(s + 39);
        rdy_a = 4'b1111; s2 = e + 1;
        pulse_nj_a();
        check("run3_restart_held", 32'(ch_resetn_a), 0);
        check("run3_restart_terr", 32'(terr_a), 0);
        check("run3_restart_err_ch", 32'(err_ch_a), 0);
        wait_to(s2 + 23);
        check("run3_in_gap", 32'(dbg_state_a), 32'(GAP));
        #2 resetn = 1'b0;
        #1;
        check("async_ch_resetn", 32'(ch_resetn_a), 0);
        check("async_busy", 32'(busy_a), 0);
        check("async_done", 32'(done_a), 0);
        check("async_terr", 32'(terr_a), 0);
        check("async_err_ch", 32'(err_ch_a), 0);
        check("async_state", 32'(dbg_state_a), 32'(IDLE));
        check("async_busy_b", 32'(busy_b), 0);
        @(negedge clk);
        check("run3_release_q", exp_q.size(), 0);
        check("run3_no_done", done_a_n, 0);

        // Run 4: after reset, new_job sampled at cycle 30.
        resetn = 1'b1; t0 = e; done_a_n = 0;
        push_rel(0, t0 + 21); push_rel(1, t0 + 27);
        push_rel(0, t0 + 50); push_rel(1, t0 + 56); push_rel(2, t0 + 62); push_rel(3, t0 + 68);
        wait_to(t0 + 29);
        check("run4_pre_job", 32'(ch_resetn_a), 32'(4'b0011));
        pulse_nj_a();
        check("run4_post_job", 32'(ch_resetn_a), 0);
        check("run4_busy", 32'(busy_a), 1);
        wait_to(t0 + 75);
        check("run4_done_edge", done_a_e - t0, 69);
        check("run4_done_count", done_a_n, 1);
        check("run4_release_q", exp_q.size(), 0);

        // Run 5: new_job held high for 5 cycles.
        done_a_n = 0;
        nj_a = 1'b1; l = e + 5;
        push_rel(0, l + 20); push_rel(1, l + 26); push_rel(2, l + 32); push_rel(3, l + 38);
        repeat (5) @(negedge clk);
        nj_a = 1'b0;
        check("run5_held", 32'(ch_resetn_a), 0);
        check("run5_state", 32'(dbg_state_a), 32'(HOLD));
        wait_to(l + 45);
        check("run5_done_edge", done_a_e - l, 39);
        check("run5_done_count", done_a_n, 1);
        check("run5_release_q", exp_q.size(), 0);

        // Single channel, no stagger: ready arrives mid-wait.
        done_b_n = 0; rdy_b = 1'b0; s = e + 1;
        nj_b = 1'b1;
        @(negedge clk);
        nj_b = 1'b0;
        wait_to(s + 7);
        check("b_released", 32'(ch_resetn_b), 1);
        check("b_waiting", 32'(dbg_state_b), 32'(WAIT_RDY));
        check("b_no_done_yet", done_b_n, 0);
        rdy_b = 1'b1;
        wait_to(s + 12);
        check("b_release_edge", rise_b_e - s, 5);
        check("b_done_edge", done_b_e - s, 8);
        check("b_done_count", done_b_n, 1);
        check("b_terr", 32'(terr_b), 0);
        check("b_busy", 32'(busy_b), 0);
        check("b_gap_cycles", gap_b_n, 0);
        check("a_gap_seen", 32'(gap_a_n != 0), 1);
        check("final_release_q", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
